// File: rtl/st2110_eth_framer.sv
// st2110_eth_framer: buffers the 32-bit packet word stream and emits padded, gap-separated Ethernet frames.
// Define ST2110_ETH_FCS_EN to append an IEEE 802.3 CRC-32 FCS word to every frame.
module st2110_eth_framer #(
    parameter int PAYLOAD_WORDS = 64,
    parameter int FIFO_DEPTH = 256,
    parameter int IDLE_TIMEOUT = 32,
    parameter int MIN_WORDS = 15,
    parameter int IFG_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam logic [2:0] IDLE = 3'd0, PAYLOAD = 3'd1, PAD = 3'd2, GAP = 3'd4;
`ifdef ST2110_ETH_FCS_EN
    localparam logic [2:0] FCS = 3'd3;
    localparam logic [2:0] TAIL = FCS;
`else
    localparam logic [2:0] TAIL = GAP;
`endif
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, len, wcnt;
    logic [TW-1:0] idle_t;
    logic [GW-1:0] gcnt;
    logic [2:0]    state;
    logic          hs, pop, push, full, start, last_pay, last_pad, short_frame;

    assign full = count == CW'(FIFO_DEPTH);
    assign hs = out_valid && out_ready;
    assign pop = hs && state == PAYLOAD;
    assign push = in_valid && (!full || pop);
    assign start = state == IDLE && (count >= CW'(PAYLOAD_WORDS) || (count != '0 && idle_t == TW'(IDLE_TIMEOUT)));
    assign last_pay = wcnt == len - CW'(1);
    assign last_pad = wcnt == CW'(MIN_WORDS - 1);
    assign short_frame = len < CW'(MIN_WORDS);
    assign out_sof = state == PAYLOAD && wcnt == '0;

`ifdef ST2110_ETH_FCS_EN
    logic [31:0] crc, crc_x;

    // reflected CRC-32, bytes taken [31:24] first, each byte LSB first
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[{~i[4:3], i[2:0]}]) ? 32'hEDB88320 : 32'd0);
        return r;
    endfunction

    assign crc_x = ~crc;
    assign out_valid = state == PAYLOAD || state == PAD || state == FCS;
    assign out_data = state == PAYLOAD ? mem[rd_ptr] :
                      state == FCS ? {crc_x[7:0], crc_x[15:8], crc_x[23:16], crc_x[31:24]} : 32'd0;
    assign out_eof = state == FCS;

    always_ff @(posedge clk) begin
        if (rst)
            crc <= 32'hFFFFFFFF;
        else if (start)
            crc <= 32'hFFFFFFFF;
        else if (hs && (state == PAYLOAD || state == PAD))
            crc <= crc_next(crc, out_data);
    end
`else
    assign out_valid = state == PAYLOAD || state == PAD;
    assign out_data = state == PAYLOAD ? mem[rd_ptr] : 32'd0;
    assign out_eof = (state == PAYLOAD && last_pay && !short_frame) || (state == PAD && last_pad);
`endif

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len <= '0;
            wcnt <= '0;
            gcnt <= '0;
            idle_t <= '0;
            frame_count <= '0;
            drop_count <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            idle_t <= (in_valid || count == '0) ? '0 :
                      (state == IDLE && idle_t != TW'(IDLE_TIMEOUT)) ? idle_t + TW'(1) : idle_t;
            if (in_valid && full && !pop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            if (hs && out_eof)
                frame_count <= frame_count + 16'd1;
            case (state)
                IDLE:
                    if (start) begin
                        state <= PAYLOAD;
                        len <= count >= CW'(PAYLOAD_WORDS) ? CW'(PAYLOAD_WORDS) : count;
                        wcnt <= '0;
                    end
                PAYLOAD:
                    if (hs) begin
                        wcnt <= wcnt + CW'(1);
                        if (last_pay) state <= short_frame ? PAD : TAIL;
                    end
                PAD:
                    if (hs) begin
                        wcnt <= wcnt + CW'(1);
                        if (last_pad) state <= TAIL;
                    end
`ifdef ST2110_ETH_FCS_EN
                FCS:
                    if (hs) state <= GAP;
`endif
                GAP: begin
                    gcnt <= gcnt + GW'(1);
                    if (gcnt == GW'(IFG_CYCLES - 1)) begin
                        gcnt <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_st2110_eth_framer.sv
// tb_st2110_eth_framer: directed stimulus with a frame-level model of the expected wire words.
// Honours ST2110_ETH_FCS_EN to expect the trailing CRC-32 word.
module tb_st2110_eth_framer;
    localparam int PW = 64, MINW = 15, IFG = 3, TO = 32;
    logic        clk = 0, rst = 1;
    logic [31:0] in_data = 0;
    logic        in_valid = 0, out_ready = 0;
    logic [31:0] out_data;
    logic        out_valid, out_sof, out_eof;
    logic [15:0] frame_count, drop_count;
    int          errors = 0, checks = 0, cyc = 0, hs_n = 0, last_cyc = 0, first_valid_cyc = -1;
    logic        bp = 0;
    logic [33:0] exp_q[$];
    logic [31:0] src[$];

    st2110_eth_framer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef ST2110_ETH_FCS_EN
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction
`endif

    // Expected wire words {sof, eof, data} for the accepted words held in src
    task automatic build_frames();
        int n, tot;
        logic [31:0] w, crc, x;
        while (src.size() != 0) begin
            n = src.size() > PW ? PW : src.size();
            tot = n < MINW ? MINW : n;
            crc = 32'hFFFFFFFF;
            for (int i = 0; i < tot; i++) begin
                w = i < n ? src.pop_front() : 32'd0;
`ifdef ST2110_ETH_FCS_EN
                for (int b = 3; b >= 0; b--) crc = crc_byte(crc, w[b*8 +: 8]);
                exp_q.push_back({i == 0, 1'b0, w});
`else
                exp_q.push_back({i == 0, i == tot - 1, w});
`endif
            end
            x = ~crc;
`ifdef ST2110_ETH_FCS_EN
            exp_q.push_back({1'b0, 1'b1, x[7:0], x[15:8], x[23:16], x[31:24]});
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bp) out_ready = ~out_ready;
    endtask

    task automatic push_seq(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            in_data = 32'(base + i);
            last_cyc = cyc;
            step();
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            step();
            k++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        exp_q.delete();
        repeat (IFG + 2) step();
    endtask

    // Compare process: word order/content on handshakes, hold while stalled, gap after eof
    logic [31:0] pd;
    logic        ps, pe, pstall = 0, garm = 0;
    int          low = 0;
    always @(negedge clk) begin
        if (rst) begin
            pstall = 0;
            garm = 0;
        end else begin
            if (pstall) chk("hold", {out_valid, out_sof, out_eof, out_data}, {1'b1, ps, pe, pd});
            if (garm && out_valid) begin
                chk("ifg", 64'(low >= IFG), 1);
                garm = 0;
            end else if (garm) low++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                hs_n++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else chk("word", {out_sof, out_eof, out_data}, exp_q.pop_front());
                if (out_eof) begin
                    garm = 1;
                    low = 0;
                end
            end
            pstall = out_valid && !out_ready;
            ps = out_sof;
            pe = out_eof;
            pd = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, base;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {out_valid, out_sof, out_eof, out_data, frame_count, drop_count}, 0);
        step();
        rst = 0;
        out_ready = 1;

        // continuous 64-word burst
        for (int i = 0; i < 64; i++) src.push_back(32'(i));
        build_frames();
        chk("model_sof0", exp_q[0], {1'b1, 1'b0, 32'h0});
`ifndef ST2110_ETH_FCS_EN
        chk("model_eof63", exp_q[63], {1'b0, 1'b1, 32'h3F});
`endif
        push_seq(0, 64);
        drain();
        chk("frame_count1", 64'(frame_count), 1);

        // short frame flushed by idle timeout and padded
        for (int i = 0; i < 5; i++) src.push_back(32'hA0 + 32'(i));
        build_frames();
`ifdef ST2110_ETH_FCS_EN
        chk("model_len", 64'(exp_q.size()), 16);
`else
        chk("model_len", 64'(exp_q.size()), 15);
        chk("model_pad_eof", exp_q[14], {1'b0, 1'b1, 32'h0});
`endif
        chk("model_a4", exp_q[4], {1'b0, 1'b0, 32'hA4});
        first_valid_cyc = -1;
        push_seq(32'hA0, 5);
        drain();
        chk("timeout_latency", 64'(first_valid_cyc - last_cyc), 64'(TO + 2));
        chk("frame_count2", 64'(frame_count), 2);

        // backpressure: out_ready toggles every cycle
        for (int i = 0; i < 64; i++) src.push_back(32'h1000 + 32'(i));
        build_frames();
        bp = 1;
        push_seq(32'h1000, 64);
        drain();
        bp = 0;
        out_ready = 1;
        chk("frame_count3", 64'(frame_count), 3);

        // overflow with the output stalled
        out_ready = 0;
        push_seq(0, 300);
        step();
        chk("drop_count", 64'(drop_count), 44);
        for (int i = 0; i < 256; i++) src.push_back(32'(i));
        build_frames();
        out_ready = 1;
        drain();
        chk("frame_count7", 64'(frame_count), 7);

        // reset after 10 handshaken words
        for (int i = 0; i < 64; i++) src.push_back(32'h2000 + 32'(i));
        build_frames();
        base = hs_n;
        push_seq(32'h2000, 64);
        k = 0;
        while (hs_n < base + 10 && k < 500) begin
            step();
            k++;
        end
        chk("hs_reached", 64'(hs_n >= base + 10), 1);
        rst = 1;
        out_ready = 0;
        exp_q.delete();
        step();
        rst = 0;
        out_ready = 1;
        @(negedge clk);
        chk("reset_mid", {out_valid, frame_count, drop_count}, 0);
        k = 0;
        for (int i = 0; i < TO + 20; i++) begin
            step();
            if (out_valid) k++;
        end
        chk("fifo_empty_after_reset", 64'(k), 0);
        for (int i = 0; i < 64; i++) src.push_back(32'h3000 + 32'(i));
        build_frames();
        push_seq(32'h3000, 64);
        drain();
        chk("frame_count_after_reset", 64'(frame_count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
